ysyx_25020047_seq: RTL and testbench

YSYX_25020047_SEQ -- requirements
Module: ysyx_25020047_SEQ

---
 rtl/ysyx_25020047_seq_if.sv | 31 +++
 rtl/ysyx_25020047_seq.sv | 178 +++++++++++++++++
 tb/tb_ysyx_25020047_seq.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25020047_seq_if.sv
// Bundles the fetch, execute, load/store and status signals of the instruction sequencer.
// The sequencer uses the slave view; its environment uses the master view.
interface ysyx_25020047_seq_if;
    logic        ifu_req;
    logic        ifu_rvalid;
    logic [31:0] inst_type;
    logic [31:0] exu_result;
    logic        exu_reg_wen;
    logic        exu_read;
    logic        exu_write;
    logic        lsu_req;
    logic        lsu_wen;
    logic        lsu_rvalid;
    logic        rf_wen;
    logic [31:0] pc;
    logic [31:0] snpc;
    logic        halt;
    logic        abort;
    logic [31:0] retired;
    logic [2:0]  state;

    modport slave (
        input  ifu_rvalid, inst_type, exu_result, exu_reg_wen, exu_read, exu_write, lsu_rvalid,
        output ifu_req, lsu_req, lsu_wen, rf_wen, pc, snpc, halt, abort, retired, state
    );

    modport master (
        output ifu_rvalid, inst_type, exu_result, exu_reg_wen, exu_read, exu_write, lsu_rvalid,
        input  ifu_req, lsu_req, lsu_wen, rf_wen, pc, snpc, halt, abort, retired, state
    );
endinterface

// File: rtl/ysyx_25020047_seq.sv
// Multi-cycle instruction sequencer: fetch, execute, optional memory access, writeback.
// Waits for memory are bounded by TIMEOUT; ebreak halts and illegal types or timeouts abort.
//
// state | meaning
// IDLE  | first cycle after reset
// FETCH | ifu_req held until ifu_rvalid
// EXEC  | decode one-hot type, capture type/store/writeback flags
// MEM   | lsu_req held until lsu_rvalid
// WB    | rf_wen pulse, pc and retired update
// HALT  | ebreak reached, absorbing
// ABORT | illegal type or timeout, absorbing
module ysyx_25020047_seq #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter logic [7:0]  TIMEOUT   = 8'd255,
    parameter logic [31:0] TYPE_MASK = 32'h0000_FFFF
) (
    input  logic clk,
    input  logic rst_n,
    ysyx_25020047_seq_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5,
        S_ABORT = 3'd6
    } state_e;

    localparam logic [31:0] T_EBREAK = 32'h0000_0004;
    localparam logic [31:0] T_JALR   = 32'h0000_0002;
    localparam logic [31:0] T_JAL    = 32'h0000_0400;
    localparam logic [31:0] T_BEQ    = 32'h0000_4000;
    localparam logic [31:0] T_BNE    = 32'h0000_8000;

    state_e      state_q,   state_d;
    logic [31:0] pc_q,      pc_d;
    logic [31:0] snpc_q,    snpc_d;
    logic [31:0] retired_q, retired_d;
    logic [7:0]  cnt_q,     cnt_d;
    logic [31:0] type_q,    type_d;
    logic        store_q,   store_d;
    logic        wen_q,     wen_d;
    logic        ifu_req_q, ifu_req_d;
    logic        lsu_req_q, lsu_req_d;
    logic        lsu_wen_q, lsu_wen_d;
    logic        rf_wen_q,  rf_wen_d;
    logic        halt_q,    halt_d;
    logic        abort_q,   abort_d;

    logic        type_ok;
    logic [31:0] next_pc;

    // Legal types have exactly one bit set, and only inside the decoder's type field.
    assign type_ok = (bus.inst_type != 32'd0)
                  && ((bus.inst_type & (bus.inst_type - 32'd1)) == 32'd0)
                  && ((bus.inst_type & ~TYPE_MASK) == 32'd0);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        snpc_d    = snpc_q;
        retired_d = retired_q;
        cnt_d     = cnt_q;
        type_d    = type_q;
        store_d   = store_q;
        wen_d     = wen_q;
        next_pc   = snpc_q;

        case (type_q)
            T_JAL, T_JALR, T_BEQ, T_BNE: next_pc = bus.exu_result;
            default:                     next_pc = snpc_q;
        endcase

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                cnt_d   = 8'd0;
            end
            S_FETCH: begin
                if (bus.ifu_rvalid)
                    state_d = S_EXEC;
                else if (cnt_q == TIMEOUT)
                    state_d = S_ABORT;
                else
                    cnt_d = cnt_q + 8'd1;
            end
            S_EXEC: begin
                type_d  = bus.inst_type;
                store_d = bus.exu_write;
                wen_d   = bus.exu_reg_wen;
                if (bus.inst_type == T_EBREAK)
                    state_d = S_HALT;
                else if (!type_ok)
                    state_d = S_ABORT;
                else if (bus.exu_read || bus.exu_write) begin
                    state_d = S_MEM;
                    cnt_d   = 8'd0;
                end else
                    state_d = S_WB;
            end
            S_MEM: begin
                if (bus.lsu_rvalid)
                    state_d = S_WB;
                else if (cnt_q == TIMEOUT)
                    state_d = S_ABORT;
                else
                    cnt_d = cnt_q + 8'd1;
            end
            S_WB: begin
                pc_d      = next_pc;
                snpc_d    = next_pc + 32'd4;
                retired_d = retired_q + 32'd1;
                cnt_d     = 8'd0;
                state_d   = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            S_ABORT: state_d = S_ABORT;
            default: state_d = S_ABORT;
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        ifu_req_d = (state_d == S_FETCH);
        lsu_req_d = (state_d == S_MEM);
        lsu_wen_d = (state_d == S_MEM) && store_d;
        rf_wen_d  = (state_d == S_WB) && wen_d;
        halt_d    = (state_d == S_HALT);
        abort_d   = (state_d == S_ABORT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            snpc_q    <= RESET_PC + 32'd4;
            retired_q <= 32'd0;
            cnt_q     <= 8'd0;
            type_q    <= 32'd0;
            store_q   <= 1'b0;
            wen_q     <= 1'b0;
            ifu_req_q <= 1'b0;
            lsu_req_q <= 1'b0;
            lsu_wen_q <= 1'b0;
            rf_wen_q  <= 1'b0;
            halt_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            snpc_q    <= snpc_d;
            retired_q <= retired_d;
            cnt_q     <= cnt_d;
            type_q    <= type_d;
            store_q   <= store_d;
            wen_q     <= wen_d;
            ifu_req_q <= ifu_req_d;
            lsu_req_q <= lsu_req_d;
            lsu_wen_q <= lsu_wen_d;
            rf_wen_q  <= rf_wen_d;
            halt_q    <= halt_d;
            abort_q   <= abort_d;
        end
    end

    assign bus.ifu_req = ifu_req_q;
    assign bus.lsu_req = lsu_req_q;
    assign bus.lsu_wen = lsu_wen_q;
    assign bus.rf_wen  = rf_wen_q;
    assign bus.pc      = pc_q;
    assign bus.snpc    = snpc_q;
    assign bus.halt    = halt_q;
    assign bus.abort   = abort_q;
    assign bus.retired = retired_q;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_ysyx_25020047_seq.sv
// Self-checking bench for the instruction sequencer: directed corner cases plus a randomized
// instruction stream compared against an instruction-level model of pc, retired and outcome.
module tb_ysyx_25020047_seq;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          TO     = 255;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ysyx_25020047_seq_if bus();

    ysyx_25020047_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] m_pc;
    logic [31:0] m_ret;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // 0 = plain writeback, 1 = memory access, 2 = halt, 3 = abort
    function automatic int classify(input logic [31:0] ty, input bit rd, input bit wr);
        if (ty == 32'h4) return 2;
        if ($countones(ty) != 1 || ty[31:16] != 16'd0) return 3;
        if (rd || wr) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] ty, input logic [31:0] res,
                                               input logic [31:0] pc);
        if (ty inside {32'h400, 32'h2, 32'h4000, 32'h8000}) return res;
        return pc + 32'd4;
    endfunction

    task automatic clear_inputs();
        bus.ifu_rvalid  = 1'b0;
        bus.inst_type   = 32'd0;
        bus.exu_result  = 32'd0;
        bus.exu_reg_wen = 1'b0;
        bus.exu_read    = 1'b0;
        bus.exu_write   = 1'b0;
        bus.lsu_rvalid  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_state", bus.state, 32'd0);
        check_eq("rst_pc", bus.pc, RST_PC);
        check_eq("rst_snpc", bus.snpc, RST_PC + 32'd4);
        check_eq("rst_retired", bus.retired, 32'd0);
        check_eq("rst_flags", {bus.halt, bus.abort, bus.ifu_req, bus.lsu_req, bus.lsu_wen, bus.rf_wen}, 32'd0);
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_fetch", {bus.state, bus.ifu_req}, {3'd1, 1'b1});
        m_pc  = RST_PC;
        m_ret = 32'd0;
    endtask

    // Starts at a negedge in FETCH, ends at the negedge in EXEC.
    task automatic fetch_phase(input logic [31:0] ty, input logic [31:0] res, input bit wen,
                               input bit rd, input bit wr, input int flat);
        int hi = 0;
        for (int i = 0; i < flat; i++) begin
            if (bus.ifu_req) hi++;
            bus.lsu_rvalid = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        if (bus.ifu_req) hi++;
        bus.lsu_rvalid  = 1'b0;
        bus.inst_type   = ty;
        bus.exu_result  = res;
        bus.exu_reg_wen = wen;
        bus.exu_read    = rd;
        bus.exu_write   = wr;
        bus.ifu_rvalid  = 1'b1;
        @(negedge clk);
        bus.ifu_rvalid  = 1'b0;
        check_eq("ifu_req_cycles", hi, flat + 1);
        check_eq("exec_reqs", {bus.state, bus.ifu_req, bus.lsu_req, bus.rf_wen}, {3'd2, 3'b000});
    endtask

    task automatic issue(input logic [31:0] ty, input logic [31:0] res, input bit wen,
                         input bit rd, input bit wr, input int flat, input int mlat,
                         output bit alive);
        int          cls = classify(ty, rd, wr);
        logic [31:0] npc = model_next(ty, res, m_pc);
        int          hi  = 0;
        alive = 1'b0;
        fetch_phase(ty, res, wen, rd, wr, flat);
        @(negedge clk);
        if (cls == 2) begin
            check_eq("halt_entry", {bus.halt, bus.abort, bus.state}, {2'b10, 3'd5});
            for (int i = 0; i < 20; i++) begin
                if (bus.ifu_req || bus.lsu_req || !bus.halt) hi++;
                bus.ifu_rvalid = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            bus.ifu_rvalid = 1'b0;
            check_eq("halt_quiet", hi, 32'd0);
            check_eq("halt_retired", bus.retired, m_ret);
            return;
        end
        if (cls == 3) begin
            check_eq("abort_illegal", {bus.halt, bus.abort, bus.ifu_req, bus.state}, {3'b010, 3'd6});
            return;
        end
        if (cls == 1) begin
            check_eq("lsu_wen", bus.lsu_wen, wr);
            for (int k = 0; k <= TO; k++) begin
                if (bus.lsu_req) hi++;
                if (k == TO && mlat > TO) check_eq("abort_early", bus.abort, 32'd0);
                if (k == mlat) begin
                    bus.ifu_rvalid = 1'b0;
                    bus.lsu_rvalid = 1'b1;
                    @(negedge clk);
                    bus.lsu_rvalid = 1'b0;
                    break;
                end
                bus.ifu_rvalid = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            bus.ifu_rvalid = 1'b0;
            if (mlat > TO) begin
                check_eq("timeout_req_cycles", hi, TO + 1);
                check_eq("timeout_abort", {bus.abort, bus.lsu_req, bus.state}, {2'b10, 3'd6});
                return;
            end
            check_eq("lsu_req_cycles", hi, mlat + 1);
        end
        check_eq("wb_rf_wen", {bus.state, bus.rf_wen}, {3'd4, wen});
        check_eq("wb_pc_hold", bus.pc, m_pc);
        @(negedge clk);
        check_eq("next_pc", bus.pc, npc);
        check_eq("next_snpc", bus.snpc, npc + 32'd4);
        check_eq("retired", bus.retired, m_ret + 32'd1);
        check_eq("after_wb", {bus.state, bus.rf_wen, bus.ifu_req}, {3'd1, 1'b0, 1'b1});
        m_pc  = npc;
        m_ret = m_ret + 32'd1;
        alive = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] types [7] = '{32'h1, 32'h2, 32'h20, 32'h40, 32'h400, 32'h4000, 32'h8000};
        logic [31:0] ty;
        bit          alive;

        clear_inputs();
        do_reset();

        issue(32'h1, $urandom, 1'b1, 1'b0, 1'b0, 2, 0, alive);
        check_eq("addi_pc", bus.pc, 32'h8000_0004);
        issue(32'h20, $urandom, 1'b1, 1'b1, 1'b0, 0, 3, alive);
        issue(32'h1, $urandom, 1'b1, 1'b0, 1'b0, 0, 0, alive);
        issue(32'h1, $urandom, 1'b0, 1'b0, 1'b0, 1, 0, alive);
        check_eq("pre_beq_pc", bus.pc, 32'h8000_0010);
        issue(32'h4000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 0, 0, alive);
        issue(32'h400, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 0, 0, alive);
        issue(32'h1, $urandom, 1'b1, 1'b0, 1'b0, 0, 0, alive);
        check_eq("pc_wrap", bus.pc, 32'd0);
        issue(32'h40, $urandom, 1'b0, 1'b0, 1'b1, 0, TO, alive);
        check_eq("timeout_edge_alive", alive, 1'b1);

        for (int n = 0; n < 40 && alive; n++) begin
            ty = types[$urandom_range(0, 6)];
            issue(ty, $urandom, 1'($urandom_range(0, 1)), ty == 32'h20, ty == 32'h40,
                  $urandom_range(0, 4), $urandom_range(0, 6), alive);
        end

        issue(32'h4, $urandom, 1'b1, 1'b0, 1'b0, 1, 0, alive);
        do_reset();
        issue(32'h3, $urandom, 1'b1, 1'b0, 1'b0, 0, 0, alive);
        do_reset();
        issue(32'h1_0000, $urandom, 1'b1, 1'b0, 1'b0, 0, 0, alive);
        do_reset();
        issue(32'h40, $urandom, 1'b0, 1'b0, 1'b1, 0, TO + 10, alive);
        do_reset();

        // Reset pulse while a load is outstanding, then a stale response after release.
        fetch_phase(32'h20, $urandom, 1'b1, 1'b1, 1'b0, 1);
        @(negedge clk);
        @(negedge clk);
        check_eq("mid_mem_req", {bus.state, bus.lsu_req}, {3'd3, 1'b1});
        rst_n = 1'b0;
        #1;
        check_eq("mid_mem_rst", {bus.lsu_req, bus.state}, 32'd0);
        check_eq("mid_mem_pc", bus.pc, RST_PC);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.lsu_rvalid = 1'b1;
        @(negedge clk);
        bus.lsu_rvalid = 1'b0;
        check_eq("late_rvalid_ignored", {bus.state, bus.ifu_req, bus.lsu_req}, {3'd1, 2'b10});
        check_eq("late_retired", bus.retired, 32'd0);
        m_pc  = RST_PC;
        m_ret = 32'd0;
        issue(32'h1, $urandom, 1'b1, 1'b0, 1'b0, 0, 0, alive);
        issue(32'h2, $urandom, 1'b0, 1'b0, 1'b0, 2, 0, alive);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
